// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: one in-order FIFO per warp, round-robin pick into a registered issue slot.
// Optional stall counter on perf_stall is built when VX_IBUF_PERF_EN is defined.

module vx_warp_ibuffer_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         nonempty,
   output logic         full
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   cnt;
   logic [W-1:0]     mem [DEPTH];

   // DEPTH is a power of 2, so the pointers wrap on their own
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout     = mem[rd_ptr];
   assign nonempty = (cnt != '0);
   assign full     = (cnt == (PTR_W+1)'(DEPTH));
endmodule

module vx_warp_ibuffer #(
   parameter  int NUM_WARPS = 4,
   parameter  int DEPTH     = 2,
   parameter  int NR_BITS   = 5,
   parameter  int UUID_W    = 44,
   localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               dec_valid,
   output logic               dec_ready,
   input  logic [WID_W-1:0]   dec_wid,
   input  logic [31:0]        dec_pc,
   input  logic               dec_wb,
   input  logic [NR_BITS-1:0] dec_rd,
   input  logic [NR_BITS-1:0] dec_rs1,
   input  logic [NR_BITS-1:0] dec_rs2,
   input  logic [NR_BITS-1:0] dec_rs3,
   input  logic [UUID_W-1:0]  dec_uuid,
   output logic               ib_valid,
   input  logic               ib_ready,
   output logic [WID_W-1:0]   ib_wid,
   output logic [31:0]        ib_pc,
   output logic               ib_wb,
   output logic [NR_BITS-1:0] ib_rd,
   output logic [NR_BITS-1:0] ib_rs1,
   output logic [NR_BITS-1:0] ib_rs2,
   output logic [NR_BITS-1:0] ib_rs3,
   output logic [UUID_W-1:0]  ib_uuid,
   output logic [WID_W-1:0]   ib_wid_n,
   output logic [NR_BITS-1:0] ib_rd_n,
   output logic [NR_BITS-1:0] ib_rs1_n,
   output logic [NR_BITS-1:0] ib_rs2_n,
   output logic [NR_BITS-1:0] ib_rs3_n,
   output logic [31:0]        perf_stall
);
   typedef struct packed {
      logic [31:0]        pc;
      logic               wb;
      logic [NR_BITS-1:0] rd;
      logic [NR_BITS-1:0] rs1;
      logic [NR_BITS-1:0] rs2;
      logic [NR_BITS-1:0] rs3;
      logic [UUID_W-1:0]  uuid;
   } ibuf_ent_t;

   localparam int ENT_W = $bits(ibuf_ent_t);

   ibuf_ent_t            dec_ent, head_sel, slot, slot_nxt;
   logic [ENT_W-1:0]     head [NUM_WARPS];
   logic [NUM_WARPS-1:0] nonempty, full;
   logic [WID_W-1:0]     rr, pick, rr_nxt, wid_nxt;
   logic                 pick_vld, load, slot_ld, enq_fire;

   assign dec_ent  = '{pc: dec_pc, wb: dec_wb, rd: dec_rd, rs1: dec_rs1,
                       rs2: dec_rs2, rs3: dec_rs3, uuid: dec_uuid};
   assign dec_ready = ~full[dec_wid];
   assign enq_fire  = dec_valid & dec_ready;
   assign load      = ~ib_valid | ib_ready;
   assign slot_ld   = load & pick_vld;

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      vx_warp_ibuffer_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
         .clk      (clk),
         .reset_n  (reset_n),
         .push     (enq_fire & (dec_wid == WID_W'(w))),
         .pop      (slot_ld & (pick == WID_W'(w))),
         .din      (dec_ent),
         .dout     (head[w]),
         .nonempty (nonempty[w]),
         .full     (full[w])
      );
   end

   // first non-empty warp at or after the RR pointer
   always_comb begin
      int idx;
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         idx = (int'(rr) + i) % NUM_WARPS;
         if (!pick_vld && nonempty[idx]) begin
            pick     = WID_W'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   assign rr_nxt   = (int'(pick) == NUM_WARPS - 1) ? '0 : pick + 1'b1;
   assign head_sel = ibuf_ent_t'(head[pick]);
   assign slot_nxt = slot_ld ? head_sel : slot;
   assign wid_nxt  = slot_ld ? pick : ib_wid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ib_valid <= 1'b0;
         ib_wid   <= '0;
         slot     <= '0;
         rr       <= '0;
      end else begin
         if (load) ib_valid <= pick_vld;
         if (slot_ld) begin
            ib_wid <= pick;
            slot   <= head_sel;
            rr     <= rr_nxt;
         end
      end
   end

   assign ib_pc    = slot.pc;
   assign ib_wb    = slot.wb;
   assign ib_rd    = slot.rd;
   assign ib_rs1   = slot.rs1;
   assign ib_rs2   = slot.rs2;
   assign ib_rs3   = slot.rs3;
   assign ib_uuid  = slot.uuid;
   assign ib_wid_n = wid_nxt;
   assign ib_rd_n  = slot_nxt.rd;
   assign ib_rs1_n = slot_nxt.rs1;
   assign ib_rs2_n = slot_nxt.rs2;
   assign ib_rs3_n = slot_nxt.rs3;

`ifdef VX_IBUF_PERF_EN
   logic [31:0] stall_cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                       stall_cnt <= '0;
      else if (ib_valid && !ib_ready && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
   end
   assign perf_stall = stall_cnt;
`else
   assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Directed bench for vx_warp_ibuffer (NUM_WARPS=4, DEPTH=2): latency, full, RR, lookahead, reset, perf.
module tb_vx_warp_ibuffer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        dec_valid, dec_ready, dec_wb;
   logic [1:0]  dec_wid;
   logic [31:0] dec_pc;
   logic [4:0]  dec_rd, dec_rs1, dec_rs2, dec_rs3;
   logic [43:0] dec_uuid;
   logic        ib_valid, ib_ready, ib_wb;
   logic [1:0]  ib_wid, ib_wid_n;
   logic [31:0] ib_pc, perf_stall;
   logic [4:0]  ib_rd, ib_rs1, ib_rs2, ib_rs3, ib_rd_n, ib_rs1_n, ib_rs2_n, ib_rs3_n;
   logic [43:0] ib_uuid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vx_warp_ibuffer dut (
      .clk(clk), .reset_n(reset_n),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_wid(dec_wid), .dec_pc(dec_pc),
      .dec_wb(dec_wb), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs3(dec_rs3), .dec_uuid(dec_uuid),
      .ib_valid(ib_valid), .ib_ready(ib_ready), .ib_wid(ib_wid), .ib_pc(ib_pc),
      .ib_wb(ib_wb), .ib_rd(ib_rd), .ib_rs1(ib_rs1), .ib_rs2(ib_rs2), .ib_rs3(ib_rs3),
      .ib_uuid(ib_uuid), .ib_wid_n(ib_wid_n), .ib_rd_n(ib_rd_n), .ib_rs1_n(ib_rs1_n),
      .ib_rs2_n(ib_rs2_n), .ib_rs3_n(ib_rs3_n), .perf_stall(perf_stall)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [1:0] w, input logic [31:0] pc, input logic [4:0] rd);
      dec_valid = 1'b1;
      dec_wid   = w;
      dec_pc    = pc;
      dec_wb    = 1'b1;
      dec_rd    = rd;
      dec_rs1   = rd + 5'd1;
      dec_rs2   = rd + 5'd2;
      dec_rs3   = rd + 5'd3;
      dec_uuid  = {12'h0, pc};
   endtask

   task automatic do_reset;
      reset_n   = 1'b0;
      dec_valid = 1'b0;
      ib_ready  = 1'b0;
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      dec_valid = 0; dec_wid = 0; dec_pc = 0; dec_wb = 0; dec_rd = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_rs3 = 0; dec_uuid = 0; ib_ready = 0;
      tick;
      chk("rst_valid", ib_valid, 0);
      chk("rst_pc",    ib_pc, 0);
      chk("rst_rd",    ib_rd, 0);
      chk("rst_ready", dec_ready, 1);
      chk("rst_perf",  perf_stall, 0);
      tick;
      reset_n = 1'b1;

      // latency: enqueue in N, visible in N+2
      ib_ready = 1'b1;
      enq(2'd1, 32'h80, 5'd3);
      tick;
      dec_valid = 1'b0;
      #1;
      chk("lat_n1_valid", ib_valid, 0);
      chk("lat_n1_wid_n", ib_wid_n, 1);
      chk("lat_n1_rd_n",  ib_rd_n, 3);
      tick;
      chk("lat_valid", ib_valid, 1);
      chk("lat_wid",   ib_wid, 1);
      chk("lat_pc",    ib_pc, 32'h80);
      chk("lat_rs2",   ib_rs2, 5);
      tick;
      chk("lat_drain", ib_valid, 0);

      // full: first goes to slot, next two fill warp 0
      ib_ready = 1'b0;
      enq(2'd0, 32'h100, 5'd1); tick;
      enq(2'd0, 32'h104, 5'd2); tick;
      enq(2'd0, 32'h108, 5'd3); tick;
      dec_valid = 1'b0;
      dec_wid = 2'd0; #1;
      chk("full_rdy0", dec_ready, 0);
      dec_wid = 2'd2; #1;
      chk("full_rdy2", dec_ready, 1);
      chk("full_slot", ib_pc, 32'h100);

      // simultaneous pop and blocked enqueue on the full warp
      enq(2'd0, 32'h10C, 5'd4);
      ib_ready = 1'b1;
      #1;
      chk("sim_blocked", dec_ready, 0);
      tick;
      chk("sim_pc1", ib_pc, 32'h104);
      chk("sim_accept", dec_ready, 1);
      tick;
      dec_valid = 1'b0;
      chk("sim_pc2", ib_pc, 32'h108);
      tick;
      chk("sim_pc3", ib_pc, 32'h10C);
      tick;
      chk("sim_empty", ib_valid, 0);

      // mid-operation reset discards buffered work
      ib_ready = 1'b0;
      enq(2'd1, 32'h200, 5'd1); tick;
      enq(2'd1, 32'h204, 5'd2); tick;
      enq(2'd1, 32'h208, 5'd3); tick;
      dec_valid = 1'b0;
      dec_wid = 2'd1;
      #1;
      chk("mrst_pre_rdy", dec_ready, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_valid", ib_valid, 0);
      chk("mrst_pc",    ib_pc, 0);
      chk("mrst_rdy",   dec_ready, 1);
      tick;
      reset_n  = 1'b1;
      ib_ready = 1'b1;
      tick;
      tick;
      chk("mrst_gone", ib_valid, 0);

      // round robin: warps 0..3 one instruction each
      do_reset;
      enq(2'd0, 32'h300, 5'd0); tick;
      enq(2'd1, 32'h310, 5'd1); tick;
      enq(2'd2, 32'h320, 5'd2); tick;
      enq(2'd3, 32'h330, 5'd3); tick;
      dec_valid = 1'b0;
      chk("rr_wid0", ib_wid, 0);
      ib_ready = 1'b1;
      tick; chk("rr_wid1", ib_wid, 1); chk("rr_pc1", ib_pc, 32'h310);
      tick; chk("rr_wid2", ib_wid, 2);
      tick; chk("rr_wid3", ib_wid, 3); chk("rr_pc3", ib_pc, 32'h330);
      tick; chk("rr_end",  ib_valid, 0);

      // lookahead fields
      do_reset;
      enq(2'd2, 32'h400, 5'd5); tick;
      enq(2'd3, 32'h404, 5'd7); tick;
      dec_valid = 1'b0;
      chk("la_rd",    ib_rd, 5);
      chk("la_rd_n",  ib_rd_n, 5);
      chk("la_wid_n", ib_wid_n, 2);
      tick;
      chk("la_hold_rd_n", ib_rd_n, 5);
      chk("la_hold_wid",  ib_wid, 2);
      ib_ready = 1'b1;
      #1;
      chk("la_rd_n2",  ib_rd_n, 7);
      chk("la_wid_n2", ib_wid_n, 3);
      chk("la_rs3_n2", ib_rs3_n, 10);
      tick;
      chk("la_rd2",  ib_rd, 7);
      chk("la_wid2", ib_wid, 3);

      // stall counter over 10 blocked cycles
      do_reset;
      enq(2'd0, 32'h500, 5'd1); tick;
      dec_valid = 1'b0;
      tick;
      chk("pf_valid", ib_valid, 1);
      chk("pf_start", perf_stall, 0);
      repeat (10) tick;
`ifdef VX_IBUF_PERF_EN
      chk("pf_cnt", perf_stall, 10);
`else
      chk("pf_cnt", perf_stall, 0);
`endif
      chk("pf_hold_pc", ib_pc, 32'h500);
      ib_ready = 1'b1;
      tick;
`ifdef VX_IBUF_PERF_EN
      chk("pf_after", perf_stall, 10);
`else
      chk("pf_after", perf_stall, 0);
`endif
      chk("pf_drain", ib_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
